xc_frame_serializer: RTL
========================

// Module: xc_frame_serializer
// PURPOSE
// Parametrised, double-buffered packet framer for the correlator top level.
// - On each capture strobe, snapshots header, correlator/counter payload and 64-bit timestamp footer into one frame.
// - Streams the frame as bytes to the UART/SPI transmitter over a valid/ready handshake, in ASCII-hex or raw binary.
// - Holds one frame in flight plus one pending frame; reports overruns instead of corrupting the frame being sent.
// PARAMETERS
// NUM_INPUTS           8   input channels (NUM_LINES*MUX_LINES)
// LAG_AUTO             1   auto-correlation lags per channel
// LAG_CROSS            1   cross-correlation lags per side
// DELAY_SIZE           0   delay-line size reported in header (12 bits)
// RESOLUTION          24   bits per counter; must be a multiple of 4
// HAS_CROSSCORRELATOR  1   include baseline payload (0/1)
// FEATURE_FLAGS     4'b0   header flags {cumulative,psu,leds,xc}
// BINARY               0   0: ASCII-hex nibbles + CR terminator; 1: raw bytes
// Derived: NB=NUM_INPUTS*(NUM_INPUTS-1)/2; CS=HAS_CROSSCORRELATOR*NB*(2*LAG_CROSS-1)
// Derived: PAYLOAD=((CS+NUM_INPUTS*LAG_AUTO)*2+NUM_INPUTS)*RESOLUTION; FRAME=PAYLOAD+128, zero-padded at MSB to a multiple of 8
// PORTS
// sysclk        in   1        clock; all logic on posedge
// reset         in   1        synchronous, active-high
// capture       in   1        one-cycle strobe: snapshot the inputs below
// tick          in   16       sample period in ps, header bits [63:48]
// pulses        in   PAYLOAD  packed correlator/counter results
// timestamp     in   64       footer
// tx_data       out  8        byte/char to transmitter
// tx_valid      out  1        tx_data is valid
// tx_ready      in   1        transmitter accepts tx_data this cycle
// busy          out  1        a frame is being sent or is pending
// frame_done    out  1        one-cycle pulse after the last byte is accepted
// overrun       out  1        sticky: a capture was dropped
// clear_overrun in   1        clears overrun (reset also clears it)
// BEHAVIOUR
// - Reset values: tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0; state=IDLE; both buffers empty.
// - Frame layout, MSB sent first:
//     - header = {tick, FEATURE_FLAGS, LAG_CROSS-1 [8b], LAG_AUTO-1 [8b], DELAY_SIZE [12b], NUM_INPUTS-1 [8b], RESOLUTION [8b]}
//     - then pulses[PAYLOAD-1:0], then timestamp[63:0].
// - States IDLE -> SEND -> (TERM if !BINARY) -> DONE -> IDLE, or DONE -> SEND when a pending frame exists.
// - capture in IDLE: active buffer loaded at the capture edge; tx_valid=1 on the next cycle (latency 1); busy=1 from that cycle.
// - SEND:
//     - idx counts from 0 to N-1, where N = FRAME/4 nibbles (ASCII) or FRAME/8 bytes (BINARY).
//     - ASCII mapping: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
//     - Handshake: a transfer occurs when tx_valid&tx_ready. tx_data and tx_valid stay stable while tx_ready=0. One transfer per cycle max.
// - TERM: emits 0x0D with the same handshake.
// - DONE:
//     - tx_valid=0 for exactly one cycle; frame_done=1 in that cycle.
//     - If pending is full, pending moves to active and SEND resumes next cycle with idx=0; else go IDLE, busy=0.
// - capture while state!=IDLE:
//     - pending empty: snapshot goes into pending.
//     - pending full: capture is dropped, pending is kept (oldest wins), overrun<=1.
//     - Same-cycle capture and last transfer: treated as busy, so the snapshot goes into pending.
// - clear_overrun and a new overrun in the same cycle: overrun stays 1.
// - reset mid-frame: next cycle tx_valid=0, pending discarded, state IDLE, no frame_done pulse.
// - Inputs are sampled only at the capture edge; later changes never alter a buffered frame.
// TESTING
// Common bench config: NUM_INPUTS=2, LAG_AUTO=1, LAG_CROSS=1, RESOLUTION=8, XC=1, so PAYLOAD=64, FRAME=192.
// T1 BINARY=0, tick=16'h0019, capture, tx_ready=1 -> 49 chars, first "0019", last 0x0D, frame_done at cycle 51, busy low after.
// T2 BINARY=1, timestamp=64'h0123456789ABCDEF -> 24 bytes; final 8 bytes are 01 23 45 67 89 AB CD EF.
// T3 tx_ready toggles 1,0,0,1 -> no byte lost or duplicated; tx_data stable during stalls; byte stream identical to T2.
// T4 Three captures during one frame -> 2nd frame sent after a 1-cycle gap with its own timestamp; 3rd dropped, overrun=1 until clear_overrun.
// T5 reset asserted at byte 10 -> tx_valid=0 next cycle; a subsequent capture restarts the frame from idx 0.
// T6 pulses changed after capture -> transmitted payload equals the value present at the capture edge.

Source files
------------

// File: rtl/xc_frame_serializer.sv
// xc_frame_serializer
// Double-buffered framer for the correlator top level. A capture strobe
// snapshots {header, pulses, timestamp} into one frame, which is streamed
// MSB first as ASCII-hex characters followed by CR, or as raw bytes.
// One frame is in flight and one more may wait in the pending buffer.
// Any further capture is dropped and flagged on the sticky overrun bit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing to send, waiting for capture
// SEND  | presenting nibble/byte idx of the active frame
// TERM  | presenting the CR terminator (ASCII mode only)
// DONE  | one idle handshake cycle, frame_done pulse, reload if pending
module xc_frame_serializer #(
  parameter int          NUM_INPUTS          = 8,
  parameter int          LAG_AUTO            = 1,
  parameter int          LAG_CROSS           = 1,
  parameter int          DELAY_SIZE          = 0,
  parameter int          RESOLUTION          = 24,
  parameter int          HAS_CROSSCORRELATOR = 1,
  parameter logic [3:0]  FEATURE_FLAGS       = 4'b0,
  parameter int          BINARY              = 0,
  localparam int         NB      = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  localparam int         CS      = HAS_CROSSCORRELATOR * NB * (2 * LAG_CROSS - 1),
  localparam int         PAYLOAD = ((CS + NUM_INPUTS * LAG_AUTO) * 2 + NUM_INPUTS) * RESOLUTION
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               capture,
  input  logic [15:0]        tick,
  input  logic [PAYLOAD-1:0] pulses,
  input  logic [63:0]        timestamp,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  input  logic               clear_overrun
);

  // Frame is padded with zeros at the MSB end up to a whole number of bytes.
  localparam int RAW_BITS = PAYLOAD + 128;
  localparam int FRAME    = ((RAW_BITS + 7) / 8) * 8;
  localparam int STEP     = (BINARY != 0) ? 8 : 4;
  localparam int N_UNITS  = FRAME / STEP;
  localparam int IDX_W    = $clog2(N_UNITS + 1);

  typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;

  state_t             state_q, state_d;
  logic [FRAME-1:0]   active_q;
  logic [FRAME-1:0]   pending_q;
  logic [FRAME-1:0]   snapshot;
  logic               pending_full_q;
  logic [IDX_W-1:0]   idx_q;
  logic               overrun_q;
  logic               last_unit;
  logic               load_new;
  logic               load_pend;
  logic               shift_en;
  logic               to_pend;
  logic               drop;

  function automatic logic [7:0] to_hex(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Assemble the frame image from the live inputs; only latched on capture.
  always_comb begin
    snapshot = '0;
    snapshot[RAW_BITS-1:0] = {tick, FEATURE_FLAGS, 8'(LAG_CROSS - 1), 8'(LAG_AUTO - 1),
                              12'(DELAY_SIZE), 8'(NUM_INPUTS - 1), 8'(RESOLUTION),
                              pulses, timestamp};
  end

  assign last_unit = (idx_q == IDX_W'(N_UNITS - 1));

  // Captures arriving mid-frame go to pending if it is free. DONE reloads
  // directly, so it is excluded here. A full pending buffer is never replaced.
  assign to_pend = capture && (state_q == SEND || state_q == TERM) && !pending_full_q;
  assign drop    = capture && (state_q != IDLE) && pending_full_q;

  assign busy    = (state_q != IDLE) || pending_full_q;
  assign overrun = overrun_q;

  // State register.
  always_ff @(posedge sysclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_d    = state_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load_new = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = (BINARY != 0) ? active_q[FRAME-1 -: 8] : to_hex(active_q[FRAME-1 -: 4]);
        if (tx_ready) begin
          if (last_unit) state_d = (BINARY != 0) ? DONE : TERM;
          else           shift_en = 1'b1;
        end
      end
      TERM: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        if (pending_full_q) begin
          load_pend = 1'b1;
          state_d   = SEND;
        end else if (capture) begin
          load_new = 1'b1;
          state_d  = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Active shift buffer, pending buffer and the sticky overrun flag.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      idx_q          <= '0;
      overrun_q      <= 1'b0;
    end else begin
      if (load_new) begin
        active_q <= snapshot;
        idx_q    <= '0;
      end else if (load_pend) begin
        active_q <= pending_q;
        idx_q    <= '0;
      end else if (shift_en) begin
        active_q <= active_q << STEP;
        idx_q    <= idx_q + IDX_W'(1);
      end

      if (to_pend) begin
        pending_q      <= snapshot;
        pending_full_q <= 1'b1;
      end else if (load_pend) begin
        pending_full_q <= 1'b0;
      end

      // A new drop wins over a simultaneous clear so no overrun goes unseen.
      if (drop)               overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
    end
  end

endmodule
